// File: rtl/memory_read_streamer.sv
// Read-side initiator for a producer-owned ring buffer: issues credited reads across the
// fixed memory latency and lands returned words in a first-word-fall-through register FIFO.
module memory_read_streamer #(
  parameter int WIDTH          = 20,
  parameter int DEPTH_LOG2     = 5,
  parameter int READ_LATENCY   = 3,
  parameter int WRITE_SETTLE   = 2,
  parameter int OUT_DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_LOG2:0]   writePtr,
  output logic [DEPTH_LOG2:0]   readPtr,
  output logic [DEPTH_LOG2-1:0] readAddr,
  output logic                  readAddressStall,
  input  logic [WIDTH-1:0]      memDataIn,
  output logic [WIDTH-1:0]      dataOut,
  output logic                  dataOutValid,
  input  logic                  dataOutReady
);

  localparam int PW        = DEPTH_LOG2 + 1;
  localparam int OUT_DEPTH = 1 << OUT_DEPTH_LOG2;
  localparam int CW        = OUT_DEPTH_LOG2 + 2;

  logic [PW-1:0]             r_settle [WRITE_SETTLE];
  logic [PW-1:0]             r_readPtr;
  logic [DEPTH_LOG2-1:0]     r_addr;
  logic [READ_LATENCY-1:0]   r_vld;
  logic [WIDTH-1:0]          r_fifo [OUT_DEPTH];
  logic [OUT_DEPTH_LOG2-1:0] r_rdIdx;
  logic [OUT_DEPTH_LOG2-1:0] r_wrIdx;
  logic [OUT_DEPTH_LOG2:0]   r_count;

  logic [PW-1:0] w_avail;
  logic [CW-1:0] w_inFlight;
  logic          w_credit;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;

  // Producer pointer settles before its word may be read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WRITE_SETTLE; i++) r_settle[i] <= '0;
    end else begin
      r_settle[0] <= writePtr;
      for (int i = 1; i < WRITE_SETTLE; i++) r_settle[i] <= r_settle[i-1];
    end
  end

  always_comb begin
    w_inFlight = '0;
    for (int i = 0; i < READ_LATENCY; i++) w_inFlight = w_inFlight + CW'(r_vld[i]);
  end

  // A slot is reserved at issue time, so the tail push can never find the FIFO full
  assign w_avail  = r_settle[WRITE_SETTLE-1] - r_readPtr;
  assign w_credit = (w_inFlight + CW'(r_count)) < CW'(OUT_DEPTH);
  assign w_issue  = (w_avail != '0) && w_credit;
  assign w_push   = r_vld[READ_LATENCY-1];
  assign w_pop    = dataOutValid && dataOutReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_readPtr <= '0;
      r_addr    <= '0;
      r_vld     <= '0;
    end else begin
      r_vld[0] <= w_issue;
      for (int i = 1; i < READ_LATENCY; i++) r_vld[i] <= r_vld[i-1];
      if (w_issue) begin
        r_readPtr <= r_readPtr + PW'(1);
        r_addr    <= r_readPtr[DEPTH_LOG2-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_DEPTH; i++) r_fifo[i] <= '0;
      r_rdIdx <= '0;
      r_wrIdx <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wrIdx] <= memDataIn;
        r_wrIdx         <= r_wrIdx + OUT_DEPTH_LOG2'(1);
      end
      if (w_pop) r_rdIdx <= r_rdIdx + OUT_DEPTH_LOG2'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (OUT_DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (OUT_DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign readPtr          = r_readPtr;
  assign readAddressStall = !w_issue;
  assign readAddr         = w_issue ? r_readPtr[DEPTH_LOG2-1:0] : r_addr;
  assign dataOut          = r_fifo[r_rdIdx];
  assign dataOutValid     = (r_count != '0);

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == (OUT_DEPTH_LOG2+1)'(OUT_DEPTH))));

endmodule

// File: tb/tb_memory_read_streamer.sv
// Bench for memory_read_streamer: an M20K-latency instance with a producer model and
// scoreboards, plus an MLAB-latency instance for the short-latency throughput case.
module tb_memory_read_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [5:0]  wp, rp, wp2, rp2;
  logic [4:0]  ra, ra2;
  logic        stall, stall2;
  logic [19:0] mdi, mdi2, dout, dout2;
  logic        dv, dv2, rdy, rdy2;

  logic [19:0] mem  [32];
  logic [19:0] mem2 [32];
  logic [19:0] dp   [3];
  logic [19:0] dp2  [2];

  logic [19:0] exp_q  [$];
  logic [4:0]  addr_q [$];
  logic [19:0] exp2_q [$];

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  memory_read_streamer u_dut (
    .clk(clk), .rst(rst), .writePtr(wp), .readPtr(rp), .readAddr(ra),
    .readAddressStall(stall), .memDataIn(mdi), .dataOut(dout),
    .dataOutValid(dv), .dataOutReady(rdy)
  );

  memory_read_streamer #(.READ_LATENCY(2), .OUT_DEPTH_LOG2(2)) u_dut_mlab (
    .clk(clk), .rst(rst), .writePtr(wp2), .readPtr(rp2), .readAddr(ra2),
    .readAddressStall(stall2), .memDataIn(mdi2), .dataOut(dout2),
    .dataOutValid(dv2), .dataOutReady(rdy2)
  );

  // Memory models: address sampled at the edge, data emerges READ_LATENCY cycles after issue
  always @(posedge clk) begin
    dp[0]  <= mem[ra];
    dp[1]  <= dp[0];
    dp[2]  <= dp[1];
    dp2[0] <= mem2[ra2];
    dp2[1] <= dp2[0];
  end
  assign mdi  = dp[2];
  assign mdi2 = dp2[1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop side: issued addresses and accepted words
  always @(negedge clk) begin
    if (!rst) begin
      if (!stall) begin
        if (addr_q.size() == 0) check("issue_unexpected", 32'(addr_q.size()), 32'd1);
        else begin
          logic [4:0] ea;
          ea = addr_q.pop_front();
          check("issue_addr", 32'(ra), 32'(ea));
        end
      end
      if (dv && rdy) begin
        xfers++;
        if (exp_q.size() == 0) check("data_unexpected", 32'(exp_q.size()), 32'd1);
        else begin
          logic [19:0] ed;
          ed = exp_q.pop_front();
          check("data", 32'(dout), 32'(ed));
        end
      end
    end
  end

  task automatic put(input logic [19:0] d);
    mem[wp[4:0]] = d;
    exp_q.push_back(d);
    addr_q.push_back(wp[4:0]);
    wp = wp + 6'd1;
  endtask

  task automatic put2(input logic [19:0] d);
    mem2[wp2[4:0]] = d;
    exp2_q.push_back(d);
    wp2 = wp2 + 6'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wp  = '0;
    wp2 = '0;
    rdy = 1'b0;
    exp_q.delete();
    addr_q.delete();
    exp2_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int limit);
    int n;
    n   = 0;
    rdy = 1'b1;
    while (exp_q.size() != 0 && n < limit) begin @(posedge clk); #1; n++; end
    check("drain_data_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    check("drain_addr_empty", 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int produced;
    int guard;
    int space;
    int n;
    int x0;
    logic [5:0]  diff;
    logic [19:0] first;

    rst = 1'b1; wp = '0; wp2 = '0; rdy = 1'b0; rdy2 = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_readptr", 32'(rp), 32'd0);
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_valid", 32'(dv), 32'd0);
    check("rst_dataout", 32'(dout), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_stall", 32'(stall), 32'd1);

    // Short burst: latency and back-to-back words
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) put(20'(10 + i));
    lat = 0;
    while (!dv && lat < 20) begin @(posedge clk); #1; lat++; end
    check("t1_latency", 32'(lat), 32'd6);
    for (int i = 1; i < 4; i++) begin @(posedge clk); #1; check("t1_consecutive", 32'(dv), 32'd1); end
    @(posedge clk); #1;
    check("t1_drained", 32'(dv), 32'd0);
    check("t1_readptr", 32'(rp), 32'd4);

    // Full ring with back-pressure
    do_reset();
    for (int i = 0; i < 32; i++) put(20'($urandom));
    first = exp_q[0];
    repeat (12) begin @(posedge clk); #1; end
    check("t2_readptr_held", 32'(rp), 32'd4);
    check("t2_stall", 32'(stall), 32'd1);
    check("t2_valid", 32'(dv), 32'd1);
    check("t2_head", 32'(dout), 32'(first));
    drain(400);
    check("t2_readptr_end", 32'(rp), 32'd32);

    // Walk the pointer up to 62, then wrap through 63 -> 0
    for (int i = 0; i < 30; i++) put(20'($urandom));
    drain(400);
    check("t3_readptr_62", 32'(rp), 32'd62);
    for (int i = 0; i < 4; i++) put(20'($urandom));
    drain(100);
    check("t3_readptr_wrap", 32'(rp), 32'd2);

    // Random ready and bursty producer
    x0 = xfers; produced = 0; guard = 0;
    while (produced < 1000 && guard < 20000) begin
      @(posedge clk); #1;
      rdy   = 1'($urandom_range(0, 1));
      diff  = wp - rp;
      space = 32 - int'(diff);
      n     = int'($urandom_range(0, 3));
      if (n > space) n = space;
      if (n > 1000 - produced) n = 1000 - produced;
      for (int j = 0; j < n; j++) put(20'($urandom));
      produced += n;
      guard++;
    end
    check("t4_produced", 32'(produced), 32'd1000);
    drain(2000);
    check("t4_transfers", 32'(xfers - x0), 32'd1000);

    // Reset while reads are in flight and words are buffered
    do_reset();
    for (int i = 0; i < 8; i++) put(20'($urandom));
    guard = 0;
    while (!dv && guard < 20) begin @(posedge clk); #1; guard++; end
    check("t5_prefill_valid", 32'(dv), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    wp  = '0;
    exp_q.delete();
    addr_q.delete();
    #1;
    check("t5_valid_async", 32'(dv), 32'd0);
    @(posedge clk); #1;
    check("t5_valid_next", 32'(dv), 32'd0);
    rst = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t5_quiet_valid", 32'(dv), 32'd0);
      check("t5_quiet_stall", 32'(stall), 32'd1);
    end
    check("t5_readptr", 32'(rp), 32'd0);

    // MLAB latency: full rate through a 4-deep FIFO
    rdy2 = 1'b1;
    for (int i = 0; i < 16; i++) put2(20'($urandom));
    lat = 0;
    while (!dv2 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("t6_latency", 32'(lat), 32'd5);
    for (int i = 0; i < 16; i++) begin
      logic [19:0] ed;
      ed = (exp2_q.size() != 0) ? exp2_q.pop_front() : 20'hFFFFF;
      check("t6_sustained_valid", 32'(dv2), 32'd1);
      check("t6_data", 32'(dout2), 32'(ed));
      @(posedge clk); #1;
    end
    check("t6_drained", 32'(dv2), 32'd0);
    check("t6_readptr", 32'(rp2), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
